pattern_scheduler: RTL and testbench
====================================

Name: pattern_scheduler

Overview:
Sequential successor to the per-turn pattern lookup. It latches one bullet pattern (per-bullet timing, speed, direction and inversed fields) and steps a time-slot counter on frame ticks. In each slot it emits one spawn event per bullet whose timing field matches the slot, using a valid/ready handshake. It sits between the pattern lookup (which supplies the packed fields) and the bullet spawner.

Parameters:
NUM_BULLETS, 24, bullets per pattern
TIMING_W, 3, bits per timing field; number of slots SLOTS = 2**TIMING_W
SPEED_W, 3, bits per speed field
DIR_W, 2, bits per direction field
TICKS_PER_SLOT, 30, tick_in pulses per slot; must be ≥1

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
tick_in  input  1  one-cycle frame tick
start_in  input  1  one-cycle request to start a pattern
pattern_valid_in  input  1  pattern fields are valid (lookup hit)
timing_in  input  NUM_BULLETS*TIMING_W  bullet i at [i*TIMING_W +: TIMING_W]
speed_in  input  NUM_BULLETS*SPEED_W  packed in the same way
direction_in  input  NUM_BULLETS*DIR_W  packed in the same way
inversed_in  input  NUM_BULLETS  bit i belongs to bullet i
spawn_ready_in  input  1  spawner accepts the event
spawn_valid_out  output  1  spawn event is valid
spawn_index_out  output  $clog2(NUM_BULLETS)  bullet index
spawn_speed_out  output  SPEED_W  bullet speed
spawn_dir_out  output  DIR_W  bullet direction
spawn_inv_out  output  1  bullet inversed flag
slot_out  output  TIMING_W  current slot
busy_out  output  1  high in every state except IDLE
done_out  output  1  one-cycle pulse at pattern end

Behaviour:
- Reset: state goes to IDLE. All outputs, latched fields, slot, index and tick count are 0. Reset in any state aborts within one cycle, and no further spawn_valid_out is asserted.
- States: IDLE, SCAN, EMIT, WAIT, DONE.
- IDLE:
  - start_in && pattern_valid_in → latch all four field vectors; slot=0, idx=0, tick count=0; go to SCAN.
  - start_in without pattern_valid_in is ignored.
- start_in is ignored in every state except IDLE. Input field changes after the latch have no effect.
- SCAN: examines bullet idx in one cycle.
  - Match (timing[idx]==slot): register that bullet's index, speed, dir and inv onto the outputs; go to EMIT.
  - No match: if idx==NUM_BULLETS-1, go to WAIT (or DONE if slot==SLOTS-1); otherwise idx++.
- EMIT:
  - spawn_valid_out=1. Payload is held stable until spawn_valid_out && spawn_ready_in.
  - On accept: spawn_valid_out drops next cycle. Then idx++ and return to SCAN, or, if idx was last, go to WAIT/DONE as above.
  - spawn_valid_out never asserts outside EMIT.
- Latency: start accepted at edge t → bullet 0 examined in cycle t+1 → earliest spawn_valid_out in cycle t+2.
- Tick counter:
  - Counts tick_in in SCAN, EMIT and WAIT, saturating at TICKS_PER_SLOT.
  - In WAIT with count==TICKS_PER_SLOT: slot++, idx=0, count=0 (a tick_in in the same cycle is not counted); go to SCAN.
  - If the count saturates during SCAN/EMIT (slow spawner), the slot advances on the first WAIT cycle. Extra ticks are dropped and do not accumulate.
- Last slot: after scanning slot SLOTS-1, go straight to DONE with no tick wait. DONE lasts one cycle with done_out=1, then IDLE.
- Bullets are emitted in ascending index order within a slot. A bullet is emitted exactly once per pattern.
- slot_out is registered and only reflects the slot counter. busy_out=0 only in IDLE.

Test Plan:
- NUM_BULLETS=4, TIMING_W=2, TICKS_PER_SLOT=2, timings {0,1,1,3}, ready tied 1 → spawns idx0 in slot0, idx1 and idx2 in slot1, idx3 in slot3; done_out pulses once; 4 accepts total.
- First spawn timing: start at edge t with timing[0]=0 → spawn_valid_out high in cycle t+2 with idx0 payload; speed/dir/inv match bullet 0 fields.
- Backpressure: ready held low 10 cycles during idx1 emit → payload stable, valid held high, exactly one accept. Ticks during the stall saturate and the slot advances on the first WAIT cycle.
- start_in with pattern_valid_in=0 → stays IDLE, busy_out=0. start_in pulsed while busy → ignored; the sequence is unchanged.
- rst_in asserted while in EMIT → next cycle spawn_valid_out=0, busy_out=0, slot_out=0; no done_out pulse.
- All timings = SLOTS-1 (3) → no spawns in slots 0–2, four back-to-back spawns in slot 3, then done_out.

Source files
------------

// File: rtl/pattern_scheduler.sv
// Steps a latched bullet pattern through its time slots on frame ticks and
// emits one valid/ready spawn event per bullet whose timing matches the slot.
module pattern_scheduler #(
  parameter int NUM_BULLETS    = 24,
  parameter int TIMING_W       = 3,
  parameter int SPEED_W        = 3,
  parameter int DIR_W          = 2,
  parameter int TICKS_PER_SLOT = 30
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 tick_in,
  input  logic                                 start_in,
  input  logic                                 pattern_valid_in,
  input  logic [NUM_BULLETS*TIMING_W-1:0]      timing_in,
  input  logic [NUM_BULLETS*SPEED_W-1:0]       speed_in,
  input  logic [NUM_BULLETS*DIR_W-1:0]         direction_in,
  input  logic [NUM_BULLETS-1:0]               inversed_in,
  input  logic                                 spawn_ready_in,
  output logic                                 spawn_valid_out,
  output logic [$clog2(NUM_BULLETS)-1:0]       spawn_index_out,
  output logic [SPEED_W-1:0]                   spawn_speed_out,
  output logic [DIR_W-1:0]                     spawn_dir_out,
  output logic                                 spawn_inv_out,
  output logic [TIMING_W-1:0]                  slot_out,
  output logic                                 busy_out,
  output logic                                 done_out
);

  localparam int SLOTS = 2**TIMING_W;
  localparam int IDX_W = $clog2(NUM_BULLETS);
  localparam int CNT_W = $clog2(TICKS_PER_SLOT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                          r_state, w_state_next;
  logic [NUM_BULLETS*TIMING_W-1:0] r_timing, w_timing_next;
  logic [NUM_BULLETS*SPEED_W-1:0]  r_speed, w_speed_next;
  logic [NUM_BULLETS*DIR_W-1:0]    r_dir, w_dir_next;
  logic [NUM_BULLETS-1:0]          r_inv, w_inv_next;
  logic [TIMING_W-1:0]             r_slot, w_slot_next;
  logic [IDX_W-1:0]                r_idx, w_idx_next;
  logic [CNT_W-1:0]                r_tick_cnt, w_tick_cnt_next;
  logic [IDX_W-1:0]                r_spawn_index, w_spawn_index_next;
  logic [SPEED_W-1:0]              r_spawn_speed, w_spawn_speed_next;
  logic [DIR_W-1:0]                r_spawn_dir, w_spawn_dir_next;
  logic                            r_spawn_inv, w_spawn_inv_next;

  logic [TIMING_W-1:0] w_timing_arr [NUM_BULLETS];
  logic [SPEED_W-1:0]  w_speed_arr  [NUM_BULLETS];
  logic [DIR_W-1:0]    w_dir_arr    [NUM_BULLETS];

  for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_unpack
    assign w_timing_arr[gi] = r_timing[gi*TIMING_W +: TIMING_W];
    assign w_speed_arr[gi]  = r_speed[gi*SPEED_W +: SPEED_W];
    assign w_dir_arr[gi]    = r_dir[gi*DIR_W +: DIR_W];
  end

  logic   w_last_idx;
  logic   w_last_slot;
  logic   w_tick_sat;
  logic   w_match;
  state_t w_end_state;

  assign w_last_idx  = (r_idx == IDX_W'(NUM_BULLETS - 1));
  assign w_last_slot = (r_slot == TIMING_W'(SLOTS - 1));
  assign w_tick_sat  = (r_tick_cnt == CNT_W'(TICKS_PER_SLOT));
  assign w_match     = (w_timing_arr[r_idx] == r_slot);
  // Final slot finishes without waiting out its ticks.
  assign w_end_state = w_last_slot ? S_DONE : S_WAIT;

  always_comb begin
    w_state_next       = r_state;
    w_timing_next      = r_timing;
    w_speed_next       = r_speed;
    w_dir_next         = r_dir;
    w_inv_next         = r_inv;
    w_slot_next        = r_slot;
    w_idx_next         = r_idx;
    w_tick_cnt_next    = r_tick_cnt;
    w_spawn_index_next = r_spawn_index;
    w_spawn_speed_next = r_spawn_speed;
    w_spawn_dir_next   = r_spawn_dir;
    w_spawn_inv_next   = r_spawn_inv;

    // Ticks beyond saturation are dropped, so a stalled slot never banks time.
    if ((r_state == S_SCAN || r_state == S_EMIT || r_state == S_WAIT) &&
        tick_in && !w_tick_sat) begin
      w_tick_cnt_next = r_tick_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (start_in && pattern_valid_in) begin
          w_timing_next   = timing_in;
          w_speed_next    = speed_in;
          w_dir_next      = direction_in;
          w_inv_next      = inversed_in;
          w_slot_next     = '0;
          w_idx_next      = '0;
          w_tick_cnt_next = '0;
          w_state_next    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_match) begin
          w_spawn_index_next = r_idx;
          w_spawn_speed_next = w_speed_arr[r_idx];
          w_spawn_dir_next   = w_dir_arr[r_idx];
          w_spawn_inv_next   = r_inv[r_idx];
          w_state_next       = S_EMIT;
        end else if (w_last_idx) begin
          w_state_next = w_end_state;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      S_EMIT: begin
        if (spawn_ready_in) begin
          if (w_last_idx) begin
            w_state_next = w_end_state;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_state_next = S_SCAN;
          end
        end
      end
      S_WAIT: begin
        if (w_tick_sat) begin
          w_slot_next     = r_slot + 1'b1;
          w_idx_next      = '0;
          w_tick_cnt_next = '0;
          w_state_next    = S_SCAN;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_timing      <= '0;
      r_speed       <= '0;
      r_dir         <= '0;
      r_inv         <= '0;
      r_slot        <= '0;
      r_idx         <= '0;
      r_tick_cnt    <= '0;
      r_spawn_index <= '0;
      r_spawn_speed <= '0;
      r_spawn_dir   <= '0;
      r_spawn_inv   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_timing      <= w_timing_next;
      r_speed       <= w_speed_next;
      r_dir         <= w_dir_next;
      r_inv         <= w_inv_next;
      r_slot        <= w_slot_next;
      r_idx         <= w_idx_next;
      r_tick_cnt    <= w_tick_cnt_next;
      r_spawn_index <= w_spawn_index_next;
      r_spawn_speed <= w_spawn_speed_next;
      r_spawn_dir   <= w_spawn_dir_next;
      r_spawn_inv   <= w_spawn_inv_next;
    end
  end

  assign spawn_valid_out = (r_state == S_EMIT);
  assign spawn_index_out = r_spawn_index;
  assign spawn_speed_out = r_spawn_speed;
  assign spawn_dir_out   = r_spawn_dir;
  assign spawn_inv_out   = r_spawn_inv;
  assign slot_out        = r_slot;
  assign busy_out        = (r_state != S_IDLE);
  assign done_out        = (r_state == S_DONE);

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler: 4 bullets, 4 slots, 2 ticks per slot.
module tb_pattern_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        tick_in = 1'b0;
  logic        start_in = 1'b0;
  logic        pattern_valid_in = 1'b0;
  logic [7:0]  timing_in = '0;
  logic [11:0] speed_in = '0;
  logic [7:0]  direction_in = '0;
  logic [3:0]  inversed_in = '0;
  logic        spawn_ready_in = 1'b1;
  logic        spawn_valid_out;
  logic [1:0]  spawn_index_out;
  logic [2:0]  spawn_speed_out;
  logic [1:0]  spawn_dir_out;
  logic        spawn_inv_out;
  logic [1:0]  slot_out;
  logic        busy_out;
  logic        done_out;

  pattern_scheduler #(
    .NUM_BULLETS(4), .TIMING_W(2), .SPEED_W(3), .DIR_W(2), .TICKS_PER_SLOT(2)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .start_in(start_in),
    .pattern_valid_in(pattern_valid_in), .timing_in(timing_in), .speed_in(speed_in),
    .direction_in(direction_in), .inversed_in(inversed_in),
    .spawn_ready_in(spawn_ready_in), .spawn_valid_out(spawn_valid_out),
    .spawn_index_out(spawn_index_out), .spawn_speed_out(spawn_speed_out),
    .spawn_dir_out(spawn_dir_out), .spawn_inv_out(spawn_inv_out),
    .slot_out(slot_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         acc_n = 0;
  int         done_n = 0;
  logic [1:0] acc_idx  [16];
  logic [1:0] acc_slot [16];
  logic [5:0] acc_pay  [16];

  // Expected {speed, dir, inv} of each bullet in the reference pattern.
  function automatic logic [5:0] pay_of(input int i);
    case (i)
      0:       return {3'd5, 2'd2, 1'b1};
      1:       return {3'd2, 2'd1, 1'b0};
      2:       return {3'd7, 2'd3, 1'b1};
      default: return {3'd1, 2'd0, 1'b1};
    endcase
  endfunction

  function automatic logic [5:0] pay_obs();
    return {spawn_speed_out, spawn_dir_out, spawn_inv_out};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: ticks every third cycle, accepts logged before the edge that takes them.
  task automatic step();
    tick_in = (cyc % 3 == 0);
    cyc++;
    if (spawn_valid_out && spawn_ready_in && !rst_in && acc_n < 16) begin
      acc_idx[acc_n]  = spawn_index_out;
      acc_slot[acc_n] = slot_out;
      acc_pay[acc_n]  = pay_obs();
      acc_n++;
    end
    @(posedge clk_in);
    #1;
    if (done_out) done_n++;
  endtask

  task automatic set_fields(input logic [7:0] tim);
    timing_in    = tim;
    speed_in     = {3'd1, 3'd7, 3'd2, 3'd5};
    direction_in = {2'd0, 2'd3, 2'd1, 2'd2};
    inversed_in  = 4'b1101;
  endtask

  task automatic start_pattern();
    acc_n = 0;
    done_n = 0;
    start_in = 1'b1;
    pattern_valid_in = 1'b1;
    step();
    start_in = 1'b0;
    pattern_valid_in = 1'b0;
  endtask

  task automatic run_until_done(input string tag);
    bit saw = 1'b0;
    for (int i = 0; i < 400 && !saw; i++) begin
      step();
      if (done_out) saw = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(saw), 32'd1);
    step();
    chk({tag, "_done_one_cycle"}, 32'(done_out), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy_out), 32'd0);
    chk({tag, "_done_count"}, 32'(done_n), 32'd1);
  endtask

  task automatic chk_acc(input string tag, input int k, input int eidx, input int eslot);
    chk({tag, "_idx"}, 32'(acc_idx[k]), 32'(eidx));
    chk({tag, "_slot"}, 32'(acc_slot[k]), 32'(eslot));
    chk({tag, "_payload"}, 32'(acc_pay[k]), 32'(pay_of(eidx)));
  endtask

  initial begin
    bit found;
    int bad;

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(spawn_valid_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_slot", 32'(slot_out), 32'd0);
    chk("rst_payload", 32'({spawn_index_out, pay_obs()}), 32'd0);
    rst_in = 1'b0;
    step();

    // start without a valid pattern is ignored
    set_fields({2'd3, 2'd1, 2'd1, 2'd0});
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    chk("nostart_busy", 32'(busy_out), 32'd0);
    step();
    chk("nostart_busy2", 32'(busy_out), 32'd0);

    // Main run: first-spawn latency, input changes and busy start ignored
    start_pattern();
    chk("t1_busy", 32'(busy_out), 32'd1);
    chk("t1_valid", 32'(spawn_valid_out), 32'd0);
    timing_in = 8'h00;
    speed_in = '0;
    direction_in = '0;
    inversed_in = '0;
    step();
    chk("t2_valid", 32'(spawn_valid_out), 32'd1);
    chk("t2_index", 32'(spawn_index_out), 32'd0);
    chk("t2_payload", 32'(pay_obs()), 32'(pay_of(0)));
    chk("t2_slot", 32'(slot_out), 32'd0);
    start_in = 1'b1;
    pattern_valid_in = 1'b1;
    step();
    start_in = 1'b0;
    pattern_valid_in = 1'b0;
    run_until_done("main");
    chk("main_accepts", 32'(acc_n), 32'd4);
    chk_acc("main_a0", 0, 0, 0);
    chk_acc("main_a1", 1, 1, 1);
    chk_acc("main_a2", 2, 2, 1);
    chk_acc("main_a3", 3, 3, 3);

    // Backpressure on bullet 1
    set_fields({2'd3, 2'd1, 2'd1, 2'd0});
    start_pattern();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (spawn_valid_out && spawn_index_out == 2'd1) found = 1'b1;
    end
    spawn_ready_in = 1'b0;
    chk("bp_reached", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", 32'({spawn_valid_out, spawn_index_out, pay_obs()}),
          32'({1'b1, 2'd1, pay_of(1)}));
    end
    spawn_ready_in = 1'b1;
    step();
    chk("bp_drop", 32'(spawn_valid_out), 32'd0);
    step();
    chk("bp_next_idx", 32'({spawn_valid_out, spawn_index_out}), 32'({1'b1, 2'd2}));
    step();
    step();
    chk("bp_wait_slot", 32'(slot_out), 32'd1);
    step();
    chk("bp_slot_adv", 32'(slot_out), 32'd2);
    run_until_done("bp");
    chk("bp_accepts", 32'(acc_n), 32'd4);
    chk_acc("bp_a1", 1, 1, 1);
    chk_acc("bp_a2", 2, 2, 1);

    // Reset while emitting in slot 3
    start_pattern();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (spawn_valid_out && spawn_index_out == 2'd3) found = 1'b1;
    end
    spawn_ready_in = 1'b0;
    chk("rse_reached", 32'(found), 32'd1);
    chk("rse_slot_before", 32'(slot_out), 32'd3);
    acc_n = 0;
    done_n = 0;
    rst_in = 1'b1;
    step();
    chk("rse_valid", 32'(spawn_valid_out), 32'd0);
    chk("rse_busy", 32'(busy_out), 32'd0);
    chk("rse_slot", 32'(slot_out), 32'd0);
    rst_in = 1'b0;
    spawn_ready_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (spawn_valid_out || busy_out) bad++;
    end
    chk("rse_quiet", 32'(bad), 32'd0);
    chk("rse_no_done", 32'(done_n), 32'd0);
    chk("rse_no_accept", 32'(acc_n), 32'd0);

    // All bullets in the last slot
    set_fields(8'hFF);
    start_pattern();
    run_until_done("last");
    chk("last_accepts", 32'(acc_n), 32'd4);
    for (int k = 0; k < 4; k++) chk_acc("last_a", k, k, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
